// File: rtl/pingpong_buf_ctrl.sv
// pingpong_buf_ctrl: two-buffer frame ping-pong controller; host fills one buffer while display drains the other.
// Define REPEAT_FRAME_EN to redisplay the last frame instead of stalling when the next buffer is not yet full.
module pingpong_buf_ctrl #(
  parameter int PIXELS = 100,
  parameter int AW     = 20
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic          rd_req_i,
  output logic          rd_valid_o,
  output logic          rd_sel_o,
  output logic          we0_o,
  output logic          we1_o,
  output logic          re0_o,
  output logic          re1_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          underflow_o,
  output logic [7:0]    frame_cnt_o
);
  typedef enum logic {W_IDLE, W_FILL} w_state_e;
  typedef enum logic {R_IDLE, R_DRAIN} r_state_e;
  localparam logic [AW-1:0] LAST = AW'(PIXELS - 1);
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic [1:0] st_q, st_d;
  logic wsel_q, wsel_d, rsel_q, rsel_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic rd_valid_q, rd_sel_q, underflow_q;
  logic wr_fire, rd_fire, wr_last, rd_last, release_buf;
  assign wr_ready_o  = (w_state_q == W_FILL) && !reset_i;
  assign wr_fire     = wr_ready_o && wr_valid_i;
  assign rd_fire     = (r_state_q == R_DRAIN) && rd_req_i && !reset_i;
  assign wr_last     = wr_fire && (wptr_q == LAST);
  assign rd_last     = rd_fire && (rptr_q == LAST);
`ifdef REPEAT_FRAME_EN
  // Only hand the buffer back once the other one is ready to show.
  assign release_buf = rd_last && st_q[~rsel_q];
`else
  assign release_buf = rd_last;
`endif
  assign we0_o       = wr_fire && !wsel_q;
  assign we1_o       = wr_fire && wsel_q;
  assign re0_o       = rd_fire && !rsel_q;
  assign re1_o       = rd_fire && rsel_q;
  assign wr_addr_o   = wptr_q;
  assign rd_addr_o   = rptr_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_sel_o    = rd_sel_q;
  assign underflow_o = underflow_q;
  assign frame_cnt_o = frame_cnt_q;
  always_comb begin
    st_d = st_q;
    if (wr_last) st_d[wsel_q] = 1'b1;
    if (release_buf) st_d[rsel_q] = 1'b0;
    w_state_d   = (w_state_q == W_IDLE) ? (st_q[wsel_q] ? W_IDLE : W_FILL) : (wr_last ? W_IDLE : W_FILL);
    wsel_d      = wsel_q ^ wr_last;
    wptr_d      = wr_last ? '0 : wptr_q + AW'(wr_fire);
    r_state_d   = (r_state_q == R_IDLE) ? (st_q[rsel_q] ? R_DRAIN : R_IDLE) : (release_buf ? R_IDLE : R_DRAIN);
    rsel_d      = rsel_q ^ release_buf;
    rptr_d      = rd_last ? '0 : rptr_q + AW'(rd_fire);
    frame_cnt_d = frame_cnt_q + 8'(rd_last);
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      st_q        <= '0;
      wsel_q      <= 1'b0;
      rsel_q      <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      frame_cnt_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_sel_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      st_q        <= st_d;
      wsel_q      <= wsel_d;
      rsel_q      <= rsel_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      frame_cnt_q <= frame_cnt_d;
      rd_valid_q  <= rd_fire;
      rd_sel_q    <= rd_fire && rsel_q;
      underflow_q <= rd_req_i && (r_state_q == R_IDLE);
    end
  end
endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// tb_pingpong_buf_ctrl: vector table, directed corner sequences and randomized traffic against a buffer-ownership model.
module tb_pingpong_buf_ctrl;
  localparam int P = 4;
`ifdef REPEAT_FRAME_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif
  typedef struct packed {
    logic ready, we0, we1, re0, re1;
    logic [19:0] wa, ra;
    logic rdv, rds, uf;
    logic [7:0] fc;
  } out_t;
  typedef struct packed {
    logic wv, rq;
    out_t e;
  } row_t;
  logic clk = 1'b0;
  logic reset_i = 1'b0, wr_valid_i = 1'b0, rd_req_i = 1'b0;
  logic wr_ready_o, rd_valid_o, rd_sel_o, we0_o, we1_o, re0_o, re1_o, underflow_o;
  logic [19:0] wr_addr_o, rd_addr_o;
  logic [7:0] frame_cnt_o;
  int checks = 0, errors = 0, cyc = 0;
  out_t cur;
  row_t tbl[14];
  bit [1:0] m_full;
  bit m_wb, m_rb, m_filling, m_draining, m_rdv, m_rds, m_uf, m_seeded;
  int m_wcnt, m_rcnt, m_frames;
  pingpong_buf_ctrl #(.PIXELS(P), .AW(20)) dut (
    .clock_i(clk), .reset_i(reset_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .rd_req_i(rd_req_i), .rd_valid_o(rd_valid_o), .rd_sel_o(rd_sel_o),
    .we0_o(we0_o), .we1_o(we1_o), .re0_o(re0_o), .re1_o(re1_o),
    .wr_addr_o(wr_addr_o), .rd_addr_o(rd_addr_o), .underflow_o(underflow_o), .frame_cnt_o(frame_cnt_o)
  );
  always #5 clk = ~clk;
  function automatic row_t mk(bit wv, bit rq, bit r, bit w0, bit w1, bit r0, bit r1, int wa, int ra, bit v, bit s, bit u, int f);
    mk.wv = wv;
    mk.rq = rq;
    mk.e = {r, w0, w1, r0, r1, 20'(wa), 20'(ra), v, s, u, 8'(f)};
  endfunction
  function automatic out_t expected(bit wv, bit rq, bit rs);
    bit ready, we, rd;
    ready = m_filling && !rs;
    we = ready && wv;
    rd = m_draining && rq && !rs;
    return {ready, we && !m_wb, we && m_wb, rd && !m_rb, rd && m_rb, 20'(m_wcnt), 20'(m_rcnt), m_rdv, m_rds, m_uf, 8'(m_frames % 256)};
  endfunction
  task automatic advance(bit wv, bit rq, bit rs);
    bit [1:0] full_now;
    bit we, rd;
    if (rs) begin
      m_full = 0; m_wb = 0; m_rb = 0; m_filling = 0; m_draining = 0;
      m_rdv = 0; m_rds = 0; m_uf = 0; m_wcnt = 0; m_rcnt = 0; m_frames = 0;
      return;
    end
    full_now = m_full;
    we = m_filling && wv;
    rd = m_draining && rq;
    m_uf = rq && !m_draining;
    m_rdv = rd;
    m_rds = rd && m_rb;
    if (!m_filling) m_filling = !full_now[m_wb];
    else if (we) begin
      m_wcnt = (m_wcnt + 1) % P;
      if (m_wcnt == 0) begin
        m_full[m_wb] = 1; m_wb = !m_wb; m_filling = 0;
      end
    end
    if (!m_draining) m_draining = full_now[m_rb];
    else if (rd) begin
      m_rcnt = (m_rcnt + 1) % P;
      if (m_rcnt == 0) begin
        m_frames++;
        if (!(REPEAT && !full_now[!m_rb])) begin
          m_full[m_rb] = 0; m_rb = !m_rb; m_draining = 0;
        end
      end
    end
  endtask
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask
  task automatic step(bit wv, bit rq, bit rs);
    out_t e;
    wr_valid_i = wv; rd_req_i = rq; reset_i = rs;
    #4;
    e = expected(wv, rq, rs);
    cur = {wr_ready_o, we0_o, we1_o, re0_o, re1_o, wr_addr_o, rd_addr_o, rd_valid_o, rd_sel_o, underflow_o, frame_cnt_o};
    if (m_seeded) chk("model", 64'(cur), 64'(e));
    @(posedge clk);
    advance(wv, rq, rs);
    if (rs) m_seeded = 1;
    cyc++;
    #1;
  endtask
  task automatic do_reset();
    step(0, 0, 1);
    step(0, 0, 1);
  endtask
  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 1, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    tbl[8]  = mk(0, 1, 1, 0, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    tbl[9]  = mk(0, 1, 1, 0, 0, 1, 0, 0, 3, 1, 0, 0, 0);
    tbl[10] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    tbl[11] = mk(0, 1, 1, 0, 0, REPEAT, 0, 0, 0, 0, 0, 0, 1);
    tbl[12] = mk(0, 0, 1, 0, 0, 0, 0, 0, int'(REPEAT), REPEAT, 0, !REPEAT, 1);
    tbl[13] = mk(1, 0, 1, 0, 1, 0, 0, 0, int'(REPEAT), 0, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].wv, tbl[i].rq, 0);
      chk($sformatf("tbl%0d", i), 64'(cur), 64'(tbl[i].e));
    end
    // Both buffers full, writer must stall until buffer 0 is drained.
    do_reset();
    step(0, 0, 0);
    repeat (9) step(1, 0, 0);
    step(1, 1, 0);
    chk("both_full_ready", 64'(cur.ready), 64'(0));
    repeat (3) step(0, 1, 0);
    step(0, 0, 0);
    chk("drain_ready_wait", 64'(cur.ready), 64'(0));
    step(1, 1, 0);
    chk("refill_ready", 64'(cur.ready), 64'(1));
    chk("refill_we0", 64'(cur.we0), 64'(1));
    chk("drain_buf1_re1", 64'(cur.re1), 64'(1));
    repeat (4) step(0, 1, 0);
    step(0, 1, 0);
    chk("stall_uf_a", 64'(cur.uf), 64'(!REPEAT));
    chk("stall_re1_a", 64'(cur.re1), 64'(REPEAT));
    step(0, 1, 0);
    chk("stall_uf_b", 64'(cur.uf), 64'(!REPEAT));
    chk("stall_re_b", 64'({cur.re0, cur.re1}), 64'({1'b0, REPEAT}));
    // Reset in the middle of a fill and a drain.
    do_reset();
    step(0, 0, 0);
    repeat (5) step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 1, 1);
    chk("pre_reset_ptrs", 64'({cur.wa, cur.ra}), 64'({20'd2, 20'd1}));
    chk("reset_cycle_enables", 64'({cur.ready, cur.we0, cur.we1, cur.re0, cur.re1}), 64'(0));
    step(1, 0, 0);
    chk("post_reset_zero", 64'(cur), 64'(0));
    step(1, 0, 0);
    chk("post_reset_ready", 64'({cur.ready, cur.we0, cur.wa}), 64'({1'b1, 1'b1, 20'd0}));
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 499) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
